// File: rtl/axi_udp_tx.sv
// UDP transmit path: resolves the destination MAC over ARP, then emits IPv4+UDP headers and payload to axi_eth_tx.
// Define AXI_UDP_TX_STATS_EN to add the stat_sent/stat_dropped saturating counters.
module axi_udp_tx #(
  parameter logic [23:0] MAC_MSB        = 24'h010203,
  parameter logic [23:0] MAC_LSB        = 24'h040506,
  parameter logic [15:0] IP_MSB         = 16'hc0a8,
  parameter logic [15:0] IP_LSB         = 16'h0602,
  parameter logic [7:0]  TTL            = 8'd64,
  parameter logic [15:0] LOOKUP_TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_hdr_valid,
  output logic        s_hdr_ready,
  input  logic [31:0] s_hdr_dst_ip,
  input  logic [15:0] s_hdr_src_port,
  input  logic [15:0] s_hdr_dst_port,
  input  logic [15:0] s_hdr_length,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        arp_lookup_req,
  output logic [31:0] arp_lookup_ip,
  input  logic        arp_lookup_valid,
  input  logic [47:0] arp_lookup_mac,
  output logic        eth_req,
  input  logic        eth_ack,
  output logic [47:0] eth_dst_mac,
  output logic [47:0] eth_src_mac,
  output logic [15:0] eth_ethertype,
  output logic [7:0]  eth_axis_tdata,
  output logic        eth_axis_tlast,
  output logic        eth_axis_tvalid,
  input  logic        eth_axis_tready,
  output logic        tx_drop
`ifdef AXI_UDP_TX_STATS_EN
  ,
  output logic [31:0] stat_sent,
  output logic [31:0] stat_dropped
`endif
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOOKUP  = 4'd1;
  localparam logic [3:0] S_CSUM1   = 4'd2;
  localparam logic [3:0] S_CSUM2   = 4'd3;
  localparam logic [3:0] S_REQ     = 4'd4;
  localparam logic [3:0] S_HDR     = 4'd5;
  localparam logic [3:0] S_PAYLOAD = 4'd6;
  localparam logic [3:0] S_PAD     = 4'd7;
  localparam logic [3:0] S_DRAIN   = 4'd8;
  localparam logic [3:0] S_DROP    = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  logic [3:0]   state;
  logic [31:0]  dst_ip;
  logic [15:0]  src_port;
  logic [15:0]  dst_port;
  logic [15:0]  len;
  logic [47:0]  dst_mac;
  logic [15:0]  ip_id;
  logic [15:0]  timer;
  logic [31:0]  csum_sum;
  logic [223:0] hdr_sr;
  logic [4:0]   hdr_idx;
  logic [15:0]  byte_cnt;
  logic         arp_req_q;

  logic [15:0] tot_len;
  logic [15:0] udp_len;
  logic        last_byte;
  logic        in_frame;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [15:0] ip_csum;

  assign tot_len   = len + 16'd28;
  assign udp_len   = len + 16'd8;
  assign last_byte = (byte_cnt == len - 16'd1);
  assign in_frame  = (state == S_REQ) || (state == S_HDR) || (state == S_PAYLOAD) || (state == S_PAD);

  // Two folds are enough: ten 16-bit words sum to under 2^20.
  assign fold1   = {1'b0, csum_sum[15:0]} + {1'b0, csum_sum[31:16]};
  assign fold2   = fold1[15:0] + {15'd0, fold1[16]};
  assign ip_csum = ~fold2;

  assign s_hdr_ready    = (state == S_IDLE) && !rst;
  assign arp_lookup_req = arp_req_q;
  assign arp_lookup_ip  = dst_ip;
  assign eth_req        = (state == S_REQ);
  assign eth_dst_mac    = in_frame ? dst_mac : 48'd0;
  assign eth_src_mac    = in_frame ? {MAC_MSB, MAC_LSB} : 48'd0;
  assign eth_ethertype  = in_frame ? 16'h0800 : 16'd0;
  assign tx_drop        = (state == S_DROP) && s_axis_tvalid && s_axis_tlast;

  always_comb begin
    s_axis_tready   = 1'b0;
    eth_axis_tvalid = 1'b0;
    eth_axis_tdata  = 8'd0;
    eth_axis_tlast  = 1'b0;
    case (state)
      S_HDR: begin
        eth_axis_tvalid = 1'b1;
        eth_axis_tdata  = hdr_sr[223:216];
      end
      S_PAYLOAD: begin
        s_axis_tready   = eth_axis_tready;
        eth_axis_tvalid = s_axis_tvalid;
        eth_axis_tdata  = s_axis_tdata;
        eth_axis_tlast  = last_byte;
      end
      S_PAD: begin
        eth_axis_tvalid = 1'b1;
        eth_axis_tlast  = last_byte;
      end
      S_DRAIN, S_DROP: s_axis_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dst_ip    <= 32'd0;
      src_port  <= 16'd0;
      dst_port  <= 16'd0;
      len       <= 16'd0;
      dst_mac   <= 48'd0;
      ip_id     <= 16'd0;
      timer     <= 16'd0;
      csum_sum  <= 32'd0;
      hdr_sr    <= 224'd0;
      hdr_idx   <= 5'd0;
      byte_cnt  <= 16'd0;
      arp_req_q <= 1'b0;
    end else begin
      arp_req_q <= 1'b0;
      case (state)
        S_IDLE: if (s_hdr_valid) begin
          dst_ip   <= s_hdr_dst_ip;
          src_port <= s_hdr_src_port;
          dst_port <= s_hdr_dst_port;
          len      <= s_hdr_length;
          if (s_hdr_length == 16'd0 || s_hdr_length > 16'd1472) begin
            state <= S_DROP;
          end else begin
            state     <= S_LOOKUP;
            arp_req_q <= 1'b1;
            timer     <= 16'd0;
          end
        end
        S_LOOKUP: begin
          if (arp_lookup_valid) begin
            dst_mac <= arp_lookup_mac;
            state   <= S_CSUM1;
          end else if (timer == LOOKUP_TIMEOUT) begin
            state <= S_DROP;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_CSUM1: begin
          csum_sum <= 32'h4500 + {16'd0, tot_len} + {16'd0, ip_id} + 32'h4000 + {16'd0, TTL, 8'h11}
                    + {16'd0, IP_MSB} + {16'd0, IP_LSB} + {16'd0, dst_ip[31:16]} + {16'd0, dst_ip[15:0]};
          state    <= S_CSUM2;
        end
        S_CSUM2: begin
          hdr_sr <= {16'h4500, tot_len, ip_id, 16'h4000, TTL, 8'h11, ip_csum, IP_MSB, IP_LSB,
                     dst_ip, src_port, dst_port, udp_len, 16'h0000};
          state  <= S_REQ;
        end
        S_REQ: if (eth_ack) begin
          hdr_idx <= 5'd0;
          state   <= S_HDR;
        end
        S_HDR: if (eth_axis_tready) begin
          hdr_sr  <= {hdr_sr[215:0], 8'h00};
          hdr_idx <= hdr_idx + 5'd1;
          if (hdr_idx == 5'd27) begin
            byte_cnt <= 16'd0;
            state    <= S_PAYLOAD;
          end
        end
        // Output length is fixed by the header; the input's own tlast only picks pad or drain.
        S_PAYLOAD: if (s_axis_tvalid && eth_axis_tready) begin
          byte_cnt <= byte_cnt + 16'd1;
          if (last_byte) state <= s_axis_tlast ? S_DONE : S_DRAIN;
          else if (s_axis_tlast) state <= S_PAD;
        end
        S_PAD: if (eth_axis_tready) begin
          byte_cnt <= byte_cnt + 16'd1;
          if (last_byte) state <= S_DONE;
        end
        S_DRAIN: if (s_axis_tvalid && s_axis_tlast) state <= S_DONE;
        S_DROP:  if (s_axis_tvalid && s_axis_tlast) state <= S_IDLE;
        S_DONE: begin
          ip_id <= ip_id + 16'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_UDP_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_sent    <= 32'd0;
      stat_dropped <= 32'd0;
    end else begin
      if (state == S_DONE && stat_sent != 32'hFFFFFFFF) stat_sent <= stat_sent + 32'd1;
      if (tx_drop && stat_dropped != 32'hFFFFFFFF) stat_dropped <= stat_dropped + 32'd1;
    end
  end
`endif

endmodule
